// File: rtl/phase2.sv
// Vault unlock stage 2: once armed by stage 1, accepts a 3-digit keypad code
// with an inter-digit timeout and a bounded number of attempts.
module phase2 #(
   parameter logic [3:0]  CODE_D0        = 4'd7,
   parameter logic [3:0]  CODE_D1        = 4'd2,
   parameter logic [3:0]  CODE_D2        = 4'd9,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned MAX_ATTEMPTS   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       phase1_done,
   input  logic       phase1_fail,
   input  logic [3:0] key_in,
   input  logic       key_valid,
   output logic       armed,
   output logic [1:0] attempts_left,
   output logic       timeout_pulse,
   output logic       phase2_done,
   output logic       phase2_fail
);

   localparam logic [7:0] TIMER_LAST   = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] ATTEMPTS_MAX = 2'(MAX_ATTEMPTS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_DONE,
      S_FAIL
   } state_t;

   state_t     state;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [1:0] digit_cnt;
   logic [7:0] timer;
   logic [1:0] attempts_used;

   logic       third_key;
   logic       code_match;
   logic       expire;
   logic       entry_bad;
   logic [1:0] attempts_next;
   logic       lockout;

   always_comb begin
      // NOTE: every signal gets a default first, so no path through this block can infer a latch.
      third_key     = 1'b0;
      code_match    = 1'b0;
      expire        = 1'b0;
      entry_bad     = 1'b0;
      attempts_next = attempts_used;
      lockout       = 1'b0;

      if (state == S_ENTRY) begin
         third_key  = key_valid && (digit_cnt == 2'd2);
         // The third digit is compared straight from key_in; it is not yet in digit2.
         code_match = third_key && (digit0 == CODE_D0) && (digit1 == CODE_D1)
                      && (key_in == CODE_D2);
         // A key on the would-be timeout cycle is accepted instead.
         expire     = !key_valid && (digit_cnt != 2'd0) && (timer == TIMER_LAST);
         entry_bad  = (third_key && !code_match) || expire;
      end

      if (attempts_used < ATTEMPTS_MAX) begin
         attempts_next = attempts_used + 2'd1;
      end
      lockout = (attempts_next == ATTEMPTS_MAX);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         // NOTE: the digit registers are reset explicitly so no partial code survives a reset.
         digit0        <= 4'd0;
         digit1        <= 4'd0;
         digit2        <= 4'd0;
         digit_cnt     <= 2'd0;
         timer         <= 8'd0;
         attempts_used <= 2'd0;
         armed         <= 1'b0;
         attempts_left <= ATTEMPTS_MAX;
         timeout_pulse <= 1'b0;
         phase2_done   <= 1'b0;
         phase2_fail   <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;

         case (state)
            S_IDLE: begin
               if (phase1_fail) begin
                  state       <= S_FAIL;
                  phase2_fail <= 1'b1;
               end else if (phase1_done) begin
                  state     <= S_ENTRY;
                  armed     <= 1'b1;
                  digit_cnt <= 2'd0;
                  timer     <= 8'd0;
               end
            end

            S_ENTRY: begin
               if (key_valid) begin
                  timer <= 8'd0;
                  case (digit_cnt)
                     2'd0: begin
                        digit0    <= key_in;
                        digit_cnt <= 2'd1;
                     end
                     2'd1: begin
                        digit1    <= key_in;
                        digit_cnt <= 2'd2;
                     end
                     default: begin
                        digit2    <= key_in;
                        digit_cnt <= 2'd0;
                     end
                  endcase
               end else if (expire) begin
                  timeout_pulse <= 1'b1;
                  digit_cnt     <= 2'd0;
                  timer         <= 8'd0;
               end else if (digit_cnt != 2'd0) begin
                  timer <= timer + 8'd1;
               end

               if (code_match) begin
                  state       <= S_DONE;
                  armed       <= 1'b0;
                  phase2_done <= 1'b1;
               end else if (entry_bad) begin
                  attempts_used <= attempts_next;
                  attempts_left <= ATTEMPTS_MAX - attempts_next;
                  if (lockout) begin
                     state       <= S_FAIL;
                     armed       <= 1'b0;
                     phase2_fail <= 1'b1;
                  end
               end
            end

            // Terminal: only reset leaves DONE or FAIL.
            S_DONE: state <= S_DONE;
            S_FAIL: state <= S_FAIL;

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_phase2.sv
// Directed bench for phase2: a per-cycle vector table plus hand-written
// timeout sequences.
module tb_phase2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       phase1_done = 1'b0;
   logic       phase1_fail = 1'b0;
   logic [3:0] key_in = 4'd0;
   logic       key_valid = 1'b0;
   logic       armed;
   logic [1:0] attempts_left;
   logic       timeout_pulse;
   logic       phase2_done;
   logic       phase2_fail;

   int total = 0;
   int bad   = 0;

   phase2 dut (
      .clk           (clk),
      .reset         (reset),
      .phase1_done   (phase1_done),
      .phase1_fail   (phase1_fail),
      .key_in        (key_in),
      .key_valid     (key_valid),
      .armed         (armed),
      .attempts_left (attempts_left),
      .timeout_pulse (timeout_pulse),
      .phase2_done   (phase2_done),
      .phase2_fail   (phase2_fail)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       pd;
      logic       pf;
      logic [3:0] key;
      logic       kv;
      logic       e_armed;
      logic [1:0] e_left;
      logic       e_to;
      logic       e_done;
      logic       e_fail;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic rst, input logic pd, input logic pf,
                              input logic [3:0] key, input logic kv,
                              input logic e_armed, input logic [1:0] e_left,
                              input logic e_to, input logic e_done, input logic e_fail);
      vec_t r;
      r.rst = rst; r.pd = pd; r.pf = pf; r.key = key; r.kv = kv;
      r.e_armed = e_armed; r.e_left = e_left; r.e_to = e_to;
      r.e_done = e_done; r.e_fail = e_fail;
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic e_armed, input logic [1:0] e_left,
                            input logic e_to, input logic e_done, input logic e_fail);
      check({tag, ".armed"}, 8'(armed), 8'(e_armed));
      check({tag, ".attempts_left"}, 8'(attempts_left), 8'(e_left));
      check({tag, ".timeout_pulse"}, 8'(timeout_pulse), 8'(e_to));
      check({tag, ".phase2_done"}, 8'(phase2_done), 8'(e_done));
      check({tag, ".phase2_fail"}, 8'(phase2_fail), 8'(e_fail));
   endtask

   // Drive inputs on the falling edge, let one rising edge pass, sample 1 time unit later.
   task automatic step(input logic rst, input logic pd, input logic pf,
                       input logic [3:0] key, input logic kv);
      @(negedge clk);
      reset = rst; phase1_done = pd; phase1_fail = pf; key_in = key; key_valid = kv;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n, input string tag, input logic [1:0] e_left);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
         check_all($sformatf("%s.idle%0d", tag, i + 1), 1'b1, e_left, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      // Correct code
      vecs.push_back(v(1,0,0,4'd0,0, 0,2'd3,0,0,0));
      vecs.push_back(v(0,1,0,4'd0,0, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd7,1, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd2,1, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd9,1, 0,2'd3,0,1,0));
      vecs.push_back(v(0,1,1,4'd1,1, 0,2'd3,0,1,0));
      // Upstream fail, with phase1_done high in the same cycle
      vecs.push_back(v(1,0,0,4'd0,0, 0,2'd3,0,0,0));
      vecs.push_back(v(0,1,1,4'd0,0, 0,2'd3,0,0,1));
      vecs.push_back(v(0,0,0,4'd7,1, 0,2'd3,0,0,1));
      vecs.push_back(v(0,0,0,4'd2,1, 0,2'd3,0,0,1));
      vecs.push_back(v(0,0,0,4'd9,1, 0,2'd3,0,0,1));
      vecs.push_back(v(0,1,0,4'd0,0, 0,2'd3,0,0,1));
      // Upstream fail alone
      vecs.push_back(v(1,0,0,4'd0,0, 0,2'd3,0,0,0));
      vecs.push_back(v(0,0,1,4'd0,0, 0,2'd3,0,0,1));
      // Keys in IDLE are ignored, then wrong middle digit, then retry
      vecs.push_back(v(1,0,0,4'd0,0, 0,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd7,1, 0,2'd3,0,0,0));
      vecs.push_back(v(0,1,0,4'd0,0, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,1,4'd7,1, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd3,1, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd9,1, 1,2'd2,0,0,0));
      vecs.push_back(v(0,0,0,4'd0,0, 1,2'd2,0,0,0));
      vecs.push_back(v(0,0,0,4'd7,1, 1,2'd2,0,0,0));
      vecs.push_back(v(0,0,0,4'd2,1, 1,2'd2,0,0,0));
      vecs.push_back(v(0,0,0,4'd9,1, 0,2'd2,0,1,0));
      // Lockout after three wrong entries
      vecs.push_back(v(1,0,0,4'd0,0, 0,2'd3,0,0,0));
      vecs.push_back(v(0,1,0,4'd0,0, 1,2'd3,0,0,0));
      for (int a = 0; a < 3; a++) begin
         vecs.push_back(v(0,0,0,4'd1,1, 1,2'd3 - 2'(a),0,0,0));
         vecs.push_back(v(0,0,0,4'd1,1, 1,2'd3 - 2'(a),0,0,0));
         if (a < 2)
            vecs.push_back(v(0,0,0,4'd1,1, 1,2'd2 - 2'(a),0,0,0));
         else
            vecs.push_back(v(0,0,0,4'd1,1, 0,2'd0,0,0,1));
      end
      vecs.push_back(v(0,0,0,4'd7,1, 0,2'd0,0,0,1));
      vecs.push_back(v(0,0,0,4'd2,1, 0,2'd0,0,0,1));
      vecs.push_back(v(0,0,0,4'd9,1, 0,2'd0,0,0,1));
      // Reset mid-entry; stale digits must not survive
      vecs.push_back(v(1,0,0,4'd0,0, 0,2'd3,0,0,0));
      vecs.push_back(v(0,1,0,4'd0,0, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd7,1, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd2,1, 1,2'd3,0,0,0));
      vecs.push_back(v(1,0,0,4'd0,0, 0,2'd3,0,0,0));
      vecs.push_back(v(0,1,0,4'd0,0, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd9,1, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd7,1, 1,2'd3,0,0,0));
      vecs.push_back(v(0,0,0,4'd2,1, 1,2'd2,0,0,0));
      vecs.push_back(v(0,0,0,4'd9,1, 1,2'd2,0,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].pd, vecs[i].pf, vecs[i].key, vecs[i].kv);
         check_all($sformatf("vec%0d", i), vecs[i].e_armed, vecs[i].e_left,
                   vecs[i].e_to, vecs[i].e_done, vecs[i].e_fail);
      end

      // Timeout: key 7 then 16 idle cycles; pulse only on the 16th
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'd7, 1'b1);
      idle_cycles(15, "to", 2'd3);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      check_all("to.expire", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      check_all("to.after", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'd7, 1'b1);
      step(1'b0, 1'b0, 1'b0, 4'd2, 1'b1);
      step(1'b0, 1'b0, 1'b0, 4'd9, 1'b1);
      check_all("to.retry", 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);

      // Key arriving on the 16th idle cycle wins over the timeout
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'd7, 1'b1);
      idle_cycles(15, "kw1", 2'd3);
      step(1'b0, 1'b0, 1'b0, 4'd2, 1'b1);
      check_all("kw.key2", 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      idle_cycles(15, "kw2", 2'd3);
      step(1'b0, 1'b0, 1'b0, 4'd9, 1'b1);
      check_all("kw.key9", 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);

      // A timeout that exhausts the last attempt locks out on the same edge
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int a = 0; a < 2; a++) begin
         step(1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
         step(1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
         step(1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
      end
      step(1'b0, 1'b0, 1'b0, 4'd7, 1'b1);
      idle_cycles(15, "lk", 2'd1);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      check_all("lk.expire", 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phase2.md
# phase2

Second stage of the vault unlock chain. Consumes the latched `phase1_done`/`phase1_fail` result of the serial-code stage. Once armed, it collects a 3-digit keypad sequence under an inter-digit timeout with a limited number of attempts. It produces latched `phase2_done`/`phase2_fail` for the next stage.

## Interface
Parameters:
- `CODE_D0`, default 4'd7: first expected digit.
- `CODE_D1`, default 4'd2: second expected digit.
- `CODE_D2`, default 4'd9: third expected digit.
- `TIMEOUT_CYCLES`, default 16: maximum idle cycles allowed between digits of a partial entry. Legal range 2..255.
- `MAX_ATTEMPTS`, default 3: wrong or timed-out entries allowed before lockout. Legal range 1..3.

Ports:
- `clk` input 1: the single clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `phase1_done` input 1: level, from the upstream stage; arms this block.
- `phase1_fail` input 1: level, from the upstream stage; forces fail.
- `key_in` input 4: digit value, sampled only when `key_valid`=1.
- `key_valid` input 1: one-cycle strobe per keypress.
- `armed` output 1: high while in ENTRY.
- `attempts_left` output 2: equals `MAX_ATTEMPTS` minus attempts used.
- `timeout_pulse` output 1: one-cycle pulse when a partial entry expires.
- `phase2_done` output 1: latched success.
- `phase2_fail` output 1: latched failure.

## Operation
States are IDLE, ENTRY, DONE and FAIL. Reset forces IDLE.

IDLE:
- `phase1_fail`=1 → FAIL. This applies even when `phase1_done` is high in the same cycle; fail wins.
- Otherwise `phase1_done`=1 → ENTRY. Digit count and timer clear on this transition.
- Keys are ignored.

ENTRY:
- Each `key_valid` stores `key_in` in digit slot `digit_cnt` (0..2) and increments `digit_cnt`.
- Each `key_valid` also clears the timer.
- No comparison happens before the third digit. Wrong early digits are not revealed.
- On the third digit, all three stored digits are compared to `CODE_D0..D2`:
  - Match → DONE.
  - Mismatch → increment `attempts_used` and clear `digit_cnt`. If `attempts_used` reaches `MAX_ATTEMPTS` → FAIL; otherwise remain in ENTRY.

Timer:
- Runs only when `digit_cnt` ≠ 0.
- Increments every cycle without `key_valid`.
- When it would reach `TIMEOUT_CYCLES`, the entry expires:
  - `timeout_pulse`=1 for one cycle.
  - `digit_cnt` and timer clear.
  - `attempts_used` increments, with the same lockout rule as a mismatch.
- With `digit_cnt`=0 the block waits indefinitely.

DONE and FAIL:
- Terminal states. Only `reset` exits.
- `key_valid`, `phase1_*` and the timer are ignored.

Counters:
- `attempts_used` saturates at `MAX_ATTEMPTS`.
- `attempts_left` never underflows.

## Timing
Reset values (asynchronous):
- State IDLE.
- `armed`=0, `timeout_pulse`=0, `phase2_done`=0, `phase2_fail`=0.
- `attempts_left`=`MAX_ATTEMPTS`.
- Internal digit registers, `digit_cnt` and timer all 0.

Outputs are registered and track state as follows:
- `armed` rises on the edge that samples `phase1_done`=1 in IDLE.
- `phase2_done` or `phase2_fail` rises on the edge that samples the third `key_valid`. The result is visible one cycle after the third key is presented.
- `phase2_fail` rises one edge after `phase1_fail` is sampled in IDLE.
- `attempts_left` updates on the same edge as the mismatch or the timeout.

Timeout edge:
- Timeout fires on the edge where the timer holds `TIMEOUT_CYCLES-1` and `key_valid`=0.
- That edge is the `TIMEOUT_CYCLES`-th consecutive idle cycle after the last accepted key.
- If `key_valid`=1 on that same cycle, the key is accepted and no timeout occurs; key wins.

Other boundary cases:
- When a mismatch or timeout exhausts the attempts, the FAIL entry and the `attempts_left`=0 update occur on the same edge.
- Reset asserted mid-entry clears everything immediately. No partial digits survive.
- `phase1_done` or `phase1_fail` changing after arming has no effect.

## Test plan
- **Correct code:** reset, `phase1_done`=1, keys 7,2,9 on consecutive cycles → `armed`=1 after 1 edge; `phase2_done`=1 one cycle after key 9; `armed`=0; `attempts_left`=3.
- **Upstream fail:** `phase1_fail`=1 while in IDLE, including with `phase1_done`=1 in the same cycle → `phase2_fail`=1 next edge; later keys 7,2,9 have no effect.
- **Early wrong digit then retry:** keys 7,3,9 → no result; `attempts_left`=2; `phase2_done`/`phase2_fail` stay 0. Then keys 7,2,9 → `phase2_done`=1.
- **Timeout:** key 7, then 16 idle cycles → `timeout_pulse` for exactly one cycle on the 16th idle cycle; `attempts_left`=2. Repeat with key 2 arriving on the 16th cycle → no timeout; entry continues.
- **Lockout:** three wrong entries (1,1,1 ×3) → `attempts_left` 3→2→1→0; `phase2_fail`=1 on the third; a subsequent 7,2,9 is ignored.
- **Reset mid-entry:** keys 7,2, then assert `reset` → all outputs at reset values, `attempts_left`=3. Re-arm, then 9 alone followed by 7,2,9 → first entry is 9,7,2 (mismatch) → `attempts_left`=2.
